cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address and data width in bits.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, 16-bit words per 16-byte cache block.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port miss_detected, input, 1, a cache lookup missed this cycle.
REQ-006 SHALL have port miss_address, input, ADDR_W, byte address of the missing access.
REQ-007 SHALL have port memory_data_valid, input, 1, memory returns one word this cycle.
REQ-008 SHALL have port memory_data_in, input, ADDR_W, word returned by memory.
REQ-009 SHALL have port fsm_busy, output, 1, fill in progress; the cache stalls the pipeline while high.
REQ-010 SHALL have port memory_read_en, output, 1, read request to memory this cycle.
REQ-011 SHALL have port memory_address, output, ADDR_W, byte address of the current request.
REQ-012 SHALL have port write_data_array, output, 1, write one word into the data array.
REQ-013 SHALL have port write_word_offset, output, 3, word index within the block for that write.
REQ-014 SHALL have port write_data_out, output, ADDR_W, word to write; equals memory_data_in.
REQ-015 SHALL have port write_tag_array, output, 1, write tag and set valid for the filled line.

Function
REQ-016 SHALL implement two states: IDLE and FILL.
REQ-017 In IDLE with miss_detected=1, SHALL latch base = {miss_address[15:4], 4'b0} and enter FILL on the next edge.
REQ-018 fsm_busy SHALL be 1 exactly while in FILL (registered, no combinational path from miss_detected).
REQ-019 In FILL, SHALL issue one request per cycle: memory_read_en=1 and memory_address = base + 2*req_cnt, req_cnt 0..7.
REQ-020 After 8 requests, memory_read_en SHALL stay 0 for the rest of the fill.
REQ-021 The block SHALL count returned words (rcv_cnt) independently of requests and SHALL NOT depend on memory latency.
REQ-022 In FILL with memory_data_valid=1: write_data_array=1, write_word_offset=rcv_cnt, write_data_out=memory_data_in, all in the same cycle.
REQ-023 On the 8th valid word, write_tag_array SHALL be 1 in that same cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-024 memory_data_valid in IDLE SHALL be ignored: no array writes, no counter change.
REQ-025 miss_detected during FILL SHALL be ignored. The cache re-presents the access after fsm_busy falls.
REQ-026 Address generation SHALL stay within the block: base 0xFFF0 yields last request 0xFFFE with no carry out.
REQ-027 Counters SHALL be 3 bits plus a done flag. Completion is detected on count 7 plus valid, with no 4-bit overflow.
REQ-028 Timing: miss at cycle 0 gives FILL and the first request at cycle 1 and the last request at cycle 8. fsm_busy falls the cycle after the 8th valid.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, req_cnt=0, rcv_cnt=0 and base=0.
REQ-030 During reset, fsm_busy, memory_read_en, write_data_array and write_tag_array SHALL be 0.
REQ-030a During reset, memory_address and write_word_offset SHALL be 0.
REQ-031 Reset mid-fill SHALL abort with no tag write. A word returning after reset is released SHALL be ignored per REQ-024.

Structure
REQ-032 State encoding, BLOCK_WORDS and OFFSET_W=4 SHALL live in shared package cache_pkg.
REQ-033 A sub-module fill_word_counter (3-bit counter with enable, sync clear, async reset, terminal-count output) SHALL be instantiated twice, once for requests and once for receipts.

Verification
REQ-034 miss_address=0x1234, memory model with 4-cycle latency: requests go to 0x1230..0x123E at cycles 1-8. Writes occur at offsets 0..7 at cycles 5-12, write_tag_array=1 at cycle 12, fsm_busy=0 at cycle 13.
REQ-035 miss_address=0xFFFF: last memory_address=0xFFFE, no wrap to 0x0000.
REQ-036 Memory with irregular valid gaps (latency 4, 7, 5, ...): exactly 8 writes with offsets in order, tag write on the 8th only.
REQ-037 rst=0 asserted after the 3rd returned word: all outputs 0 immediately. Late valids produce no writes, and the state returns to IDLE.
REQ-038 miss_detected held high throughout a fill: no restart and no base change. A new fill starts only if miss_detected is still high in IDLE.
REQ-039 memory_data_valid pulses while in IDLE: write_data_array and write_tag_array remain 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-fill controller: state encoding and
// block geometry (16-byte blocks of 16-bit words).
package cache_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_W    = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage : cache_pkg

// File: rtl/fill_word_counter.sv
// Word counter for one side of a block fill (requests or receipts).
// Synchronous clear has priority over enable; tc_o flags the last word index.
module fill_word_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step when enabled (wraps at the block end).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == {W{1'b1}});

endmodule : fill_word_counter

// File: rtl/cache_fill_fsm.sv
// Cache line-fill controller: on a miss, issues one word request per cycle for
// the whole block and writes returned words into the data array as they arrive.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [ADDR_W-1:0] memory_data_in,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        write_word_offset,
  output logic [ADDR_W-1:0] write_data_out,
  output logic              write_tag_array
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              req_done_q, req_done_d;

  logic [CNT_W-1:0]  req_cnt_s, rcv_cnt_s;
  logic              req_tc_s, rcv_tc_s;
  logic              req_en_s, rcv_en_s, cnt_clr_s, tag_wr_s;
  logic              miss_offset_unused;

  assign miss_offset_unused = ^miss_address[OFFSET_W-1:0];

  fill_word_counter #(.W(CNT_W)) u_req_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr_s),
    .en_i   (req_en_s),
    .cnt_o  (req_cnt_s),
    .tc_o   (req_tc_s)
  );

  fill_word_counter #(.W(CNT_W)) u_rcv_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr_s),
    .en_i   (rcv_en_s),
    .cnt_o  (rcv_cnt_s),
    .tc_o   (rcv_tc_s)
  );

  // Next-state, base latch and per-cycle strobes; counters are held clear in IDLE.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    req_done_d = req_done_q;
    req_en_s   = 1'b0;
    rcv_en_s   = 1'b0;
    cnt_clr_s  = 1'b0;
    tag_wr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr_s  = 1'b1;
        req_done_d = 1'b0;
        if (miss_detected) begin
          base_d  = {miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        req_en_s = !req_done_q;
        rcv_en_s = memory_data_valid;
        if (req_en_s && req_tc_s) begin
          req_done_d = 1'b1;
        end else begin
          req_done_d = req_done_q;
        end
        // Completion keys off the receive side only, so memory latency is irrelevant.
        if (memory_data_valid && rcv_tc_s) begin
          tag_wr_s = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, block base and request-side done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= {ADDR_W{1'b0}};
      req_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      req_done_q <= req_done_d;
    end
  end

  // Word addresses are formed by concatenation, so no carry can leave the block.
  assign fsm_busy          = (state_q == FILL);
  assign memory_read_en    = req_en_s;
  assign memory_address    = req_en_s ? {base_q[ADDR_W-1:OFFSET_W], req_cnt_s, 1'b0}
                                      : {ADDR_W{1'b0}};
  assign write_data_array  = rcv_en_s;
  assign write_word_offset = rcv_en_s ? rcv_cnt_s : {CNT_W{1'b0}};
  assign write_data_out    = memory_data_in;
  assign write_tag_array   = tag_wr_s;

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a small in-order memory model whose
// per-request latency comes from a table.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  write_word_offset;
  logic [15:0] write_data_out;
  logic        write_tag_array;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          cyc;
  int          req_i;
  int          lat_tab [8];
  int          due_q [$];
  logic [15:0] dat_q [$];

  int          n_req, n_wr, n_tag, addr_err, ord_err, data_err, tag_err;
  int          first_req_cyc, last_req_cyc, first_wr_cyc, tag_cyc, end_cyc;
  logic [15:0] first_addr, last_addr;

  cache_fill_fsm #(.ADDR_W(16), .BLOCK_WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_word_offset (write_word_offset),
    .write_data_out    (write_data_out),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record this cycle's request, advance one clock, present any due memory word.
  task automatic tick();
    if (memory_read_en) begin
      due_q.push_back(cyc + lat_tab[req_i % 8]);
      dat_q.push_back(memory_address ^ 16'hA5A5);
      req_i++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data_in    = dat_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      memory_data_valid = 1'b0;
    end
    #1;
  endtask

  task automatic sample(input logic [15:0] exp_base);
    logic [15:0] e;
    if (memory_read_en) begin
      if (n_req == 0) begin
        first_addr    = memory_address;
        first_req_cyc = cyc;
      end
      last_addr    = memory_address;
      last_req_cyc = cyc;
      e = exp_base + 16'(2 * n_req);
      if (memory_address !== e) addr_err++;
      n_req++;
    end
    if (write_data_array) begin
      if (n_wr == 0) first_wr_cyc = cyc;
      if (write_word_offset !== 3'(n_wr)) ord_err++;
      e = (exp_base + 16'(2 * n_wr)) ^ 16'hA5A5;
      if (write_data_out !== e) data_err++;
      if (write_tag_array) begin
        n_tag++;
        tag_cyc = cyc;
        if (n_wr != 7) tag_err++;
      end
      n_wr++;
    end else if (write_tag_array) begin
      tag_err++;
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input logic [15:0] exp_base, input bit hold);
    n_req = 0; n_wr = 0; n_tag = 0; addr_err = 0; ord_err = 0; data_err = 0; tag_err = 0;
    first_req_cyc = -1; last_req_cyc = -1; first_wr_cyc = -1; tag_cyc = -1;
    first_addr = 16'h0; last_addr = 16'h0;
    cyc = 0; req_i = 0;
    miss_address  = addr;
    miss_detected = 1'b1;
    #1;
    check("busy_c0", fsm_busy, 1'b0);
    check("rden_c0", memory_read_en, 1'b0);
    tick();
    if (hold) miss_address = 16'h5678;
    else miss_detected = 1'b0;
    #1;
    for (int k = 0; k < 60 && fsm_busy; k++) begin
      sample(exp_base);
      tick();
    end
    end_cyc = cyc;
    check("fill_ends", fsm_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data_in = 16'h0;
    #12;
    check("rst_busy", fsm_busy, 1'b0);
    check("rst_rden", memory_read_en, 1'b0);
    check("rst_addr", memory_address, 16'h0);
    check("rst_wr",   write_data_array, 1'b0);
    check("rst_off",  write_word_offset, 3'd0);
    check("rst_tag",  write_tag_array, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic fill, latency 4
    for (int i = 0; i < 8; i++) lat_tab[i] = 4;
    run_fill(16'h1234, 16'h1230, 1'b0);
    check("t1_first_addr", first_addr, 16'h1230);
    check("t1_last_addr",  last_addr,  16'h123E);
    check("t1_first_req",  first_req_cyc, 1);
    check("t1_last_req",   last_req_cyc,  8);
    check("t1_n_req",      n_req, 8);
    check("t1_addr_seq",   addr_err, 0);
    check("t1_first_wr",   first_wr_cyc, 5);
    check("t1_n_wr",       n_wr, 8);
    check("t1_order",      ord_err, 0);
    check("t1_data",       data_err, 0);
    check("t1_tag_cyc",    tag_cyc, 12);
    check("t1_n_tag",      n_tag, 1);
    check("t1_busy_fall",  end_cyc, 13);

    // Top-of-memory block, latency 1
    for (int i = 0; i < 8; i++) lat_tab[i] = 1;
    run_fill(16'hFFFF, 16'hFFF0, 1'b0);
    check("t2_first_addr", first_addr, 16'hFFF0);
    check("t2_last_addr",  last_addr,  16'hFFFE);
    check("t2_addr_seq",   addr_err, 0);
    check("t2_n_wr",       n_wr, 8);
    check("t2_tag",        tag_err, 0);

    // Irregular latencies
    lat_tab[0] = 4; lat_tab[1] = 7; lat_tab[2] = 5; lat_tab[3] = 6;
    lat_tab[4] = 4; lat_tab[5] = 9; lat_tab[6] = 5; lat_tab[7] = 4;
    run_fill(16'h8A5C, 16'h8A50, 1'b0);
    check("t3_n_req",  n_req, 8);
    check("t3_n_wr",   n_wr, 8);
    check("t3_order",  ord_err, 0);
    check("t3_data",   data_err, 0);
    check("t3_n_tag",  n_tag, 1);
    check("t3_tag",    tag_err, 0);

    // Miss held through the fill; address changes mid-fill
    for (int i = 0; i < 8; i++) lat_tab[i] = 2;
    run_fill(16'h1234, 16'h1230, 1'b1);
    check("t4_addr_seq", addr_err, 0);
    check("t4_n_req",    n_req, 8);
    check("t4_n_tag",    n_tag, 1);
    tick();
    check("t4_refill_busy", fsm_busy, 1'b1);
    check("t4_refill_rden", memory_read_en, 1'b1);
    check("t4_refill_addr", memory_address, 16'h5670);
    miss_detected = 1'b0;
    for (int k = 0; k < 60 && fsm_busy; k++) tick();
    check("t4_refill_end", fsm_busy, 1'b0);

    // Valid pulses while idle
    for (int k = 0; k < 3; k++) begin
      memory_data_valid = 1'b1;
      memory_data_in    = 16'hBEEF;
      #1;
      check("t5_idle_wr",  write_data_array, 1'b0);
      check("t5_idle_tag", write_tag_array, 1'b0);
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
    for (int i = 0; i < 8; i++) lat_tab[i] = 3;
    run_fill(16'h0042, 16'h0040, 1'b0);
    check("t5_order", ord_err, 0);
    check("t5_n_wr",  n_wr, 8);

    // Reset after the third returned word
    for (int i = 0; i < 8; i++) lat_tab[i] = 4;
    cyc = 0; req_i = 0;
    miss_address = 16'h2000; miss_detected = 1'b1; #1;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("t6_3rd_wr",  write_data_array, 1'b1);
    check("t6_3rd_off", write_word_offset, 3'd2);
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_busy", fsm_busy, 1'b0);
    check("t6_rst_rden", memory_read_en, 1'b0);
    check("t6_rst_addr", memory_address, 16'h0);
    check("t6_rst_wr",   write_data_array, 1'b0);
    check("t6_rst_off",  write_word_offset, 3'd0);
    check("t6_rst_tag",  write_tag_array, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t6_late_wr",   write_data_array, 1'b0);
      check("t6_late_tag",  write_tag_array, 1'b0);
      check("t6_late_busy", fsm_busy, 1'b0);
      tick();
    end
    due_q.delete();
    dat_q.delete();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule : tb_cache_fill_fsm
